// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: validates the PC, maps kernel addresses, runs one bus read
// per request and latches the fetched word, reporting done or a coded fault.
module instruction_fetch_unit #(
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] program_counter,
  input  logic        user_mode,
  input  logic        fetch_start,
  input  logic        fetch_cancel,
  output logic        bus_request,
  output logic [31:0] bus_address,
  input  logic        bus_acknowledge,
  input  logic [31:0] bus_read_data,
  output logic [31:0] instruction,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        fetch_fault,
  output logic [1:0]  fault_code
);

  localparam int unsigned CntW = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {StIdle, StBus, StDone, StFault} state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     instr_q, instr_d;
  logic [1:0]      code_q, code_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      instr_q <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (fetch_start && !fetch_cancel) begin
          cnt_d = '0;
          if (program_counter[1:0] != 2'b00) begin
            code_d  = 2'd1;
            state_d = StFault;
          end else if (user_mode && program_counter[31]) begin
            code_d  = 2'd2;
            state_d = StFault;
          end else begin
            code_d  = 2'd0;
            // Kernel direct-mapped segment strips the top two bits.
            addr_d  = (program_counter[31:30] == 2'b11) ? {2'b00, program_counter[29:0]}
                                                        : program_counter;
            state_d = StBus;
          end
        end
      end
      StBus: begin
        cnt_d = cnt_q + 1'b1;
        if (fetch_cancel) begin
          state_d = StIdle;
        end else if (bus_acknowledge) begin
          instr_d = bus_read_data;
          state_d = StDone;
        end else if (cnt_q == CntMax) begin
          code_d  = 2'd3;
          state_d = StFault;
        end
      end
      StDone: begin
        code_d  = 2'd0;
        state_d = StIdle;
      end
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus_request = (state_q == StBus);
  assign bus_address = addr_q;
  assign instruction = instr_q;
  assign fetch_busy  = (state_q != StIdle);
  assign fetch_done  = (state_q == StDone);
  assign fetch_fault = (state_q == StFault);
  assign fault_code  = code_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; expected fetch outcomes go through a
// scoreboard queue and are compared when the unit reports done or fault.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] program_counter;
  logic        user_mode;
  logic        fetch_start;
  logic        fetch_cancel;
  logic        bus_request;
  logic [31:0] bus_address;
  logic        bus_acknowledge;
  logic [31:0] bus_read_data;
  logic [31:0] instruction;
  logic        fetch_busy;
  logic        fetch_done;
  logic        fetch_fault;
  logic [1:0]  fault_code;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        is_fault;
    logic [1:0]  code;
    logic [31:0] instr;
    logic [31:0] addr;
    int          req;
  } exp_t;

  exp_t sb[$];

  instruction_fetch_unit #(.TimeoutCycles(16)) dut (
    .clock           (clock),
    .reset           (reset),
    .program_counter (program_counter),
    .user_mode       (user_mode),
    .fetch_start     (fetch_start),
    .fetch_cancel    (fetch_cancel),
    .bus_request     (bus_request),
    .bus_address     (bus_address),
    .bus_acknowledge (bus_acknowledge),
    .bus_read_data   (bus_read_data),
    .instruction     (instruction),
    .fetch_busy      (fetch_busy),
    .fetch_done      (fetch_done),
    .fetch_fault     (fetch_fault),
    .fault_code      (fault_code)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ack_wait < 0 means the bus never acknowledges.
  task automatic do_fetch(input string name, input logic [31:0] pc, input logic um,
                          input int ack_wait, input logic [31:0] data);
    int          req;
    logic [31:0] addr_seen;
    logic        finished;
    exp_t        e;
    req       = 0;
    addr_seen = '0;
    finished  = 1'b0;
    program_counter = pc;
    user_mode       = um;
    fetch_start     = 1'b1;
    step();
    fetch_start     = 1'b0;
    program_counter = 32'h1234_5670;
    for (int i = 0; i < 40; i++) begin
      if (fetch_done || fetch_fault) begin
        finished = 1'b1;
        break;
      end
      if (bus_request) begin
        req++;
        addr_seen = bus_address;
        if (ack_wait >= 0 && req == ack_wait + 1) begin
          bus_acknowledge = 1'b1;
          bus_read_data   = data;
        end
      end
      step();
      bus_acknowledge = 1'b0;
      bus_read_data   = 32'hffff_ffff;
    end
    check({name, " finished"}, 32'(finished), 32'd1);
    if (sb.size() == 0) begin
      check({name, " scoreboard_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({name, " fault_pulse"}, 32'(fetch_fault), 32'(e.is_fault));
      check({name, " done_pulse"}, 32'(fetch_done), 32'(!e.is_fault));
      check({name, " fault_code"}, 32'(fault_code), 32'(e.code));
      check({name, " instruction"}, instruction, e.instr);
      check({name, " req_cycles"}, 32'(req), 32'(e.req));
      if (e.req > 0) check({name, " bus_address"}, addr_seen, e.addr);
    end
    step();
    check({name, " pulse_one_cycle"}, 32'(fetch_done | fetch_fault), 32'd0);
    check({name, " code_holds"}, 32'(fault_code), 32'(e.code));
    check({name, " idle"}, 32'(fetch_busy), 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    program_counter = '0;
    user_mode       = 1'b0;
    fetch_start     = 1'b0;
    fetch_cancel    = 1'b0;
    bus_acknowledge = 1'b0;
    bus_read_data   = '0;
    #3;
    check("rst bus_request", 32'(bus_request), 32'd0);
    check("rst bus_address", bus_address, 32'd0);
    check("rst instruction", instruction, 32'd0);
    check("rst flags", {28'd0, fetch_busy, fetch_done, fetch_fault, 1'b0}, 32'd0);
    check("rst fault_code", 32'(fault_code), 32'd0);
    step();
    reset = 1'b0;
    step();

    sb.push_back('{1'b0, 2'd0, 32'h1234_5678, 32'h2000_0000, 3});
    do_fetch("kseg", 32'he000_0000, 1'b0, 2, 32'h1234_5678);

    sb.push_back('{1'b1, 2'd1, 32'h1234_5678, 32'h0, 0});
    do_fetch("misaligned", 32'h9abc_9abe, 1'b0, 0, 32'h0);

    sb.push_back('{1'b1, 2'd2, 32'h1234_5678, 32'h0, 0});
    do_fetch("priv", 32'h8000_0000, 1'b1, 0, 32'h0);

    sb.push_back('{1'b0, 2'd0, 32'hcafe_f00d, 32'h8000_0000, 1});
    do_fetch("kernel_ok", 32'h8000_0000, 1'b0, 0, 32'hcafe_f00d);

    sb.push_back('{1'b1, 2'd3, 32'hcafe_f00d, 32'h0000_0004, 16});
    do_fetch("timeout", 32'hc000_0004, 1'b0, -1, 32'h0);

    // Start together with cancel in IDLE is ignored.
    program_counter = 32'he000_0008;
    fetch_start     = 1'b1;
    fetch_cancel    = 1'b1;
    step();
    fetch_start  = 1'b0;
    fetch_cancel = 1'b0;
    check("start_cancel ignored", 32'(fetch_busy), 32'd0);

    // Cancel in the second BUS cycle; a start during BUS is ignored.
    fetch_start = 1'b1;
    step();
    check("cancel req1", 32'(bus_request), 32'd1);
    check("cancel addr", bus_address, 32'h2000_0008);
    program_counter = 32'he000_0100;
    step();
    fetch_start = 1'b0;
    check("cancel req2", 32'(bus_request), 32'd1);
    check("busy start ignored addr", bus_address, 32'h2000_0008);
    fetch_cancel = 1'b1;
    step();
    fetch_cancel = 1'b0;
    check("cancel req_drop", 32'(bus_request), 32'd0);
    check("cancel idle", 32'(fetch_busy), 32'd0);
    check("cancel no_pulse", 32'(fetch_done | fetch_fault), 32'd0);
    step();
    check("cancel no_pulse2", 32'(fetch_done | fetch_fault), 32'd0);
    check("cancel instruction", instruction, 32'hcafe_f00d);

    // Stray acknowledge in IDLE leaves instruction alone.
    bus_acknowledge = 1'b1;
    bus_read_data   = 32'h5555_aaaa;
    step();
    bus_acknowledge = 1'b0;
    check("stray ack", instruction, 32'hcafe_f00d);

    // Reset mid-BUS clears everything without waiting for a clock edge.
    program_counter = 32'he000_000c;
    fetch_start     = 1'b1;
    step();
    fetch_start = 1'b0;
    check("midbus req", 32'(bus_request), 32'd1);
    reset = 1'b1;
    #1;
    check("midbus rst req", 32'(bus_request), 32'd0);
    check("midbus rst addr", bus_address, 32'd0);
    check("midbus rst instr", instruction, 32'd0);
    check("midbus rst flags", {29'd0, fetch_busy, fetch_done, fetch_fault}, 32'd0);
    check("midbus rst code", 32'(fault_code), 32'd0);
    step();
    reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
